// File: rtl/fft_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_sequencer
// Brief    : Runs one FFT frame: load input buffer, start core, wait, unload.
// Revision : 1.0 - initial release
// ============================================================================
module fft_sequencer #(
    parameter int N       = 32,
    parameter int W       = 32,
    parameter int AW      = $clog2(N),
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_ready,
    input  logic [W-1:0]  in_word,
    output logic [AW-1:0] in_idx,
    output logic          fft_load,
    output logic [AW-1:0] fft_load_addr,
    output logic [W-1:0]  fft_data_in,
    output logic          fft_start,
    input  logic          fft_done,
    output logic [AW-1:0] fft_rd_addr,
    input  logic [W-1:0]  fft_data_out,
    output logic          out_wr_en,
    output logic [AW-1:0] out_wr_idx,
    output logic [W-1:0]  out_wr_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          ack
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_UNLOAD = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          armed_q, armed_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        // Re-arming needs data_ready low, so one assertion launches one frame.
        armed_d = armed_q | ~data_ready;
        case (state_q)
            S_IDLE: begin
                if (data_ready && armed_q) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end
            end
            S_LOAD: begin
                cnt_d = cnt_q + (AW+1)'(1);
                if (cnt_q == (AW+1)'(N-1)) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion wins over a coincident timeout.
                if (fft_done) begin
                    state_d = S_UNLOAD;
                    cnt_d   = '0;
                end else if (tcnt_q == TW'(TIMEOUT-1)) begin
                    state_d = S_ERR;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_UNLOAD: begin
                cnt_d = cnt_q + (AW+1)'(1);
                if (cnt_q == (AW+1)'(N)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE, S_ERR: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic w_load;
    logic w_unload;
    logic w_wr;

    assign w_load   = (state_q == S_LOAD);
    assign w_unload = (state_q == S_UNLOAD);
    // Read data lags the address by one cycle, so writes trail reads by one.
    assign w_wr     = w_unload && (cnt_q != '0);

    assign fft_load      = w_load;
    assign in_idx        = w_load ? cnt_q[AW-1:0] : '0;
    assign fft_load_addr = w_load ? cnt_q[AW-1:0] : '0;
    assign fft_data_in   = in_word;
    assign fft_start     = (state_q == S_START);
    assign fft_rd_addr   = (w_unload && (cnt_q != (AW+1)'(N))) ? cnt_q[AW-1:0] : '0;
    assign out_wr_en     = w_wr;
    assign out_wr_idx    = w_wr ? (cnt_q[AW-1:0] - AW'(1)) : '0;
    assign out_wr_data   = fft_data_out;
    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign done          = (state_q == S_DONE);
    assign err           = (state_q == S_ERR);

endmodule
`default_nettype wire
